// File: rtl/z_stage_pkg.sv
// Shared definitions for the Z result stage: state encoding and default width.
// Optional flag outputs are enabled by the Z_FLAGS_EN macro.
package z_stage_pkg;

    localparam int Z_DATA_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOW  = ST_LOW,
        HIGH = ST_HIGH
    } z_state_e;

endpackage

// File: rtl/z_flag_gen.sv
// Zero/negative flags of an ALU result; built only when Z_FLAGS_EN is defined.
// Wide results look at the full 64-bit value, narrow ones at the low half only.
`ifdef Z_FLAGS_EN
module z_flag_gen #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] z_val,
    input  logic                wide,
    output logic                zero,
    output logic                neg
);

    always_comb begin
        zero = 1'b0;
        neg  = 1'b0;
        if (wide) begin
            zero = (z_val == '0);
            neg  = z_val[2*DATA_W-1];
        end else begin
            zero = (z_val[DATA_W-1:0] == '0);
            neg  = z_val[DATA_W-1];
        end
    end

endmodule
`endif

// File: rtl/z_result_stage.sv
// Z register stage: captures {Zhigh,Zlow} and drains one or two bus beats.
// Defining Z_FLAGS_EN adds registered z_zero/z_neg outputs.
module z_result_stage
    import z_stage_pkg::*;
#(
    parameter int DATA_W = Z_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic              alu_wide,
    input  logic [DATA_W-1:0] alu_zlow,
    input  logic [DATA_W-1:0] alu_zhigh,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_sel_high,
    output logic [DATA_W-1:0] zlow_q,
    output logic [DATA_W-1:0] zhigh_q,
    output logic [CNT_W-1:0]  result_cnt
`ifdef Z_FLAGS_EN
    ,
    output logic              z_zero,
    output logic              z_neg
`endif
);

    z_state_e state;
    z_state_e state_nxt;
    logic     wide_q;
    logic     final_beat;
    logic     done;
    logic     capture;

    always_comb begin
        state_nxt    = state;
        final_beat   = 1'b0;
        bus_valid    = 1'b0;
        bus_sel_high = 1'b0;
        unique case (state)
            IDLE: begin
                if (alu_valid) state_nxt = LOW;
            end
            LOW: begin
                bus_valid  = 1'b1;
                final_beat = !wide_q;
                if (bus_ready) begin
                    if (wide_q)         state_nxt = HIGH;
                    else if (alu_valid) state_nxt = LOW;
                    else                state_nxt = IDLE;
                end
            end
            HIGH: begin
                bus_valid    = 1'b1;
                bus_sel_high = 1'b1;
                final_beat   = 1'b1;
                if (bus_ready) state_nxt = alu_valid ? LOW : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Final-beat accept frees the stage in the same cycle (no bubble)
    assign done      = final_beat & bus_ready;
    assign alu_ready = (state == IDLE) | done;
    assign capture   = alu_valid & alu_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            wide_q     <= 1'b0;
            zlow_q     <= '0;
            zhigh_q    <= '0;
            bus_data   <= '0;
            result_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                zlow_q   <= alu_zlow;
                zhigh_q  <= alu_zhigh;
                wide_q   <= alu_wide;
                bus_data <= alu_zlow;
            end else if (state == LOW && bus_ready && wide_q) begin
                bus_data <= zhigh_q;
            end
            if (done) result_cnt <= result_cnt + 1'b1;
        end
    end

`ifdef Z_FLAGS_EN
    logic flag_zero;
    logic flag_neg;

    z_flag_gen #(
        .DATA_W(DATA_W)
    ) u_flags (
        .z_val({alu_zhigh, alu_zlow}),
        .wide (alu_wide),
        .zero (flag_zero),
        .neg  (flag_neg)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            z_zero <= 1'b0;
            z_neg  <= 1'b0;
        end else if (capture) begin
            z_zero <= flag_zero;
            z_neg  <= flag_neg;
        end
    end
`endif

endmodule

// File: tb/tb_z_result_stage.sv
// Bench for z_result_stage: directed literal scenarios plus random traffic
// checked every cycle against a beat-queue model of the stage.
module tb_z_result_stage;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic          alu_wide = 1'b0;
    logic [DW-1:0] alu_zlow = '0;
    logic [DW-1:0] alu_zhigh = '0;
    logic          bus_valid;
    logic          bus_ready = 1'b0;
    logic [DW-1:0] bus_data;
    logic          bus_sel_high;
    logic [DW-1:0] zlow_q;
    logic [DW-1:0] zhigh_q;
    logic [CW-1:0] result_cnt;
`ifdef Z_FLAGS_EN
    logic          z_zero;
    logic          z_neg;
`endif

    z_result_stage #(
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_wide    (alu_wide),
        .alu_zlow    (alu_zlow),
        .alu_zhigh   (alu_zhigh),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_data    (bus_data),
        .bus_sel_high(bus_sel_high),
        .zlow_q      (zlow_q),
        .zhigh_q     (zhigh_q),
        .result_cnt  (result_cnt)
`ifdef Z_FLAGS_EN
        ,
        .z_zero      (z_zero),
        .z_neg       (z_neg)
`endif
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of pending beats, plus the registered values
    typedef struct {
        logic [DW-1:0] data;
        logic          sel;
    } beat_t;

    beat_t         mq[$];
    int            m_cnt = 0;
    logic [DW-1:0] m_zl = '0;
    logic [DW-1:0] m_zh = '0;
    logic [DW-1:0] m_last = '0;
    logic          m_zero = 1'b0;
    logic          m_neg = 1'b0;

    // Compare process: mid-cycle, after inputs settle, before the next edge
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!clear_n) begin
                mq.delete();
                m_cnt = 0;
                m_zl = '0;
                m_zh = '0;
                m_last = '0;
                m_zero = 1'b0;
                m_neg = 1'b0;
            end
            chk("bus_valid", 64'(bus_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("bus_data", 64'(bus_data), 64'(mq[0].data));
                chk("bus_sel_high", 64'(bus_sel_high), 64'(mq[0].sel));
                m_last = mq[0].data;
            end else begin
                chk("bus_data_hold", 64'(bus_data), 64'(m_last));
                chk("bus_sel_idle", 64'(bus_sel_high), 64'd0);
            end
            if (!clear_n)
                chk("alu_ready_rst", 64'(alu_ready), 64'd1);
            else
                chk("alu_ready", 64'(alu_ready),
                    64'(mq.size() == 0 || (mq.size() == 1 && bus_ready)));
            chk("zlow_q", 64'(zlow_q), 64'(m_zl));
            chk("zhigh_q", 64'(zhigh_q), 64'(m_zh));
            chk("result_cnt", 64'(result_cnt), 64'(m_cnt));
`ifdef Z_FLAGS_EN
            chk("z_zero", 64'(z_zero), 64'(m_zero));
            chk("z_neg", 64'(z_neg), 64'(m_neg));
`endif
            if (clear_n) begin
                bit rdy;
                rdy = (mq.size() == 0) || (mq.size() == 1 && bus_ready);
                if (mq.size() > 0 && bus_ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_cnt = (m_cnt + 1) % (1 << CW);
                end
                if (alu_valid && rdy) begin
                    mq.push_back('{alu_zlow, 1'b0});
                    if (alu_wide) mq.push_back('{alu_zhigh, 1'b1});
                    m_zl = alu_zlow;
                    m_zh = alu_zhigh;
                    if (alu_wide) begin
                        m_zero = ({alu_zhigh, alu_zlow} == 64'd0);
                        m_neg  = alu_zhigh[DW-1];
                    end else begin
                        m_zero = (alu_zlow == '0);
                        m_neg  = alu_zlow[DW-1];
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic w, input logic [DW-1:0] zl,
                         input logic [DW-1:0] zh, input logic br);
        @(negedge clock);
        alu_valid = v;
        alu_wide  = w;
        alu_zlow  = zl;
        alu_zhigh = zh;
        bus_ready = br;
        #3;
    endtask

    initial begin
        // Reset
        repeat (2) drive(0, 0, '0, '0, 0);
        chk("rst_bus_valid", 64'(bus_valid), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_cnt", 64'(result_cnt), 64'd0);
        @(negedge clock);
        clear_n = 1'b1;

        // Narrow ROL result: 0x55555555 rotl 7
        drive(1, 0, 32'hAAAAAAAA, 32'h12345678, 1);
        drive(0, 0, '0, '0, 1);
        chk("rol_data", 64'(bus_data), 64'hAAAAAAAA);
        chk("rol_sel", 64'(bus_sel_high), 64'd0);
        chk("rol_valid", 64'(bus_valid), 64'd1);
        drive(0, 0, '0, '0, 0);
        chk("rol_cnt", 64'(result_cnt), 64'd1);
        chk("rol_idle", 64'(bus_valid), 64'd0);
        chk("rol_zhigh_kept", 64'(zhigh_q), 64'h12345678);

        // Wide mul result with backpressure on the high beat
        drive(1, 1, 32'h00000001, 32'hFFFFFFFF, 0);
        drive(0, 0, '0, '0, 1);
        chk("mul_lo_data", 64'(bus_data), 64'h1);
        chk("mul_lo_sel", 64'(bus_sel_high), 64'd0);
        chk("mul_lo_rdy", 64'(alu_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h007FFF80, '0, 0);
            chk("bp_data", 64'(bus_data), 64'hFFFFFFFF);
            chk("bp_sel", 64'(bus_sel_high), 64'd1);
            chk("bp_rdy", 64'(alu_ready), 64'd0);
        end
        drive(0, 0, '0, '0, 1);
        chk("mul_final_rdy", 64'(alu_ready), 64'd1);
        drive(0, 0, '0, '0, 0);
        chk("mul_cnt", 64'(result_cnt), 64'd2);
        chk("bp_not_captured", 64'(zlow_q), 64'h1);
        chk("mul_hold", 64'(bus_data), 64'hFFFFFFFF);

        // Back-to-back capture on the final-beat accept
        drive(1, 0, 32'h55555555, '0, 0);
        drive(1, 0, 32'h007FFF80, '0, 1);
        chk("b2b_rdy", 64'(alu_ready), 64'd1);
        drive(0, 0, '0, '0, 0);
        chk("b2b_valid", 64'(bus_valid), 64'd1);
        chk("b2b_data", 64'(bus_data), 64'h007FFF80);
        chk("b2b_cnt", 64'(result_cnt), 64'd3);
        drive(0, 0, '0, '0, 1);
        drive(0, 0, '0, '0, 0);
        chk("b2b_cnt2", 64'(result_cnt), 64'd4);

        // Reset mid-LOW
        drive(1, 1, 32'hDEADBEEF, 32'hCAFEF00D, 0);
        drive(0, 0, '0, '0, 0);
        chk("pre_rst_valid", 64'(bus_valid), 64'd1);
        @(negedge clock);
        clear_n = 1'b0;
        #3;
        chk("mid_rst_valid", 64'(bus_valid), 64'd0);
        chk("mid_rst_zlow", 64'(zlow_q), 64'd0);
        chk("mid_rst_cnt", 64'(result_cnt), 64'd0);
        chk("mid_rst_rdy", 64'(alu_ready), 64'd1);
        @(negedge clock);
        clear_n = 1'b1;

        // Counter wrap with 16 narrow results
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, DW'(i + 1), '0, 1);
            drive(0, 0, '0, '0, 1);
            if (i == 14) begin
                drive(0, 0, '0, '0, 0);
                chk("cnt_15", 64'(result_cnt), 64'd15);
            end
        end
        drive(0, 0, '0, '0, 0);
        chk("cnt_wrap", 64'(result_cnt), 64'd0);

`ifdef Z_FLAGS_EN
        drive(1, 0, 32'h0, 32'h1, 1);
        drive(0, 0, '0, '0, 1);
        chk("flag_zero", 64'(z_zero), 64'd1);
        chk("flag_zero_neg", 64'(z_neg), 64'd0);
        drive(1, 0, 32'h80000000, 32'h0, 1);
        drive(0, 0, '0, '0, 1);
        chk("flag_neg", 64'(z_neg), 64'd1);
        chk("flag_neg_zero", 64'(z_zero), 64'd0);
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [DW-1:0] zl;
            logic [DW-1:0] zh;
            zl = $urandom;
            zh = $urandom;
            case ($urandom_range(0, 5))
                0: zl = '0;
                1: zh = '0;
                2: begin zl = '0; zh = '0; end
                3: zh = 32'h80000000;
                default: ;
            endcase
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                  zl, zh, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 249) == 0) begin
                @(negedge clock);
                clear_n = 1'b0;
                @(negedge clock);
                clear_n = 1'b1;
            end
        end

        drive(0, 0, '0, '0, 1);
        drive(0, 0, '0, '0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
